// File: rtl/snoopy_sprite_drawer.sv
// Sprite plot back end: on a frame strobe, erases the old Snoopy sprite and
// draws it at the new Y position, streaming one pixel per cycle to the VGA adapter.
module snoopy_sprite_drawer #(
  parameter int                             SNOOPY_X      = 20,
  parameter int                             SPRITE_W      = 8,
  parameter int                             SPRITE_H      = 8,
  parameter int                             SCREEN_H      = 120,
  parameter logic [SPRITE_W*SPRITE_H-1:0]   SPRITE_MASK   = '1,
  parameter logic [2:0]                     SPRITE_COLOUR = 3'b111,
  parameter logic [2:0]                     BG_COLOUR     = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [6:0] snoopy_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam int         N        = SPRITE_W * SPRITE_H;
  localparam logic [3:0] COL_LAST = 4'(SPRITE_W - 1);
  localparam logic [3:0] ROW_LAST = 4'(SPRITE_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t     state, state_n;
  logic [3:0] col, col_n, row, row_n;
  logic [6:0] new_y, new_y_n, drawn_y, drawn_y_n;
  logic       drawn_valid, drawn_valid_n;
  logic [7:0] vga_x_n;
  logic [6:0] vga_y_n;
  logic [2:0] vga_colour_n;
  logic       vga_plot_n, busy_n, done_n;

  // Pixel presented in the next cycle: counters are the pixel being output.
  logic       pix_en, pix_erase, last;
  logic [6:0] pix_base;
  logic [7:0] pix_x, pix_y, pix_idx;
  logic [N-1:0] mask_shift;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      new_y       <= '0;
      drawn_y     <= '0;
      drawn_valid <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      row         <= row_n;
      new_y       <= new_y_n;
      drawn_y     <= drawn_y_n;
      drawn_valid <= drawn_valid_n;
      vga_x       <= vga_x_n;
      vga_y       <= vga_y_n;
      vga_colour  <= vga_colour_n;
      vga_plot    <= vga_plot_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n       = state;
    col_n         = col;
    row_n         = row;
    new_y_n       = new_y;
    drawn_y_n     = drawn_y;
    drawn_valid_n = drawn_valid;
    busy_n        = 1'b1;
    done_n        = 1'b0;
    pix_en        = 1'b0;
    pix_erase     = 1'b0;
    pix_base      = new_y;
    last          = (col == COL_LAST) && (row == ROW_LAST);

    unique case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (frame_tick) begin
          new_y_n = snoopy_y;
          col_n   = '0;
          row_n   = '0;
          busy_n  = 1'b1;
          if (drawn_valid && snoopy_y == drawn_y) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else if (drawn_valid) begin
            state_n   = S_ERASE;
            pix_en    = 1'b1;
            pix_erase = 1'b1;
            pix_base  = drawn_y;
          end else begin
            state_n  = S_DRAW;
            pix_en   = 1'b1;
            pix_base = snoopy_y;
          end
        end
      end
      S_ERASE: begin
        pix_en = 1'b1;
        if (last) begin
          state_n = S_DRAW;
          col_n   = '0;
          row_n   = '0;
        end else begin
          pix_erase = 1'b1;
          pix_base  = drawn_y;
          if (col == COL_LAST) begin
            col_n = '0;
            row_n = row + 4'd1;
          end else begin
            col_n = col + 4'd1;
          end
        end
      end
      S_DRAW: begin
        if (last) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          pix_en = 1'b1;
          if (col == COL_LAST) begin
            col_n = '0;
            row_n = row + 4'd1;
          end else begin
            col_n = col + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_n       = S_IDLE;
        busy_n        = 1'b0;
        drawn_y_n     = new_y;
        drawn_valid_n = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    pix_x      = 8'(SNOOPY_X) + {4'b0, col_n};
    pix_y      = {1'b0, pix_base} + {4'b0, row_n};
    pix_idx    = {4'b0, row_n} * 8'(SPRITE_W) + {4'b0, col_n};
    mask_shift = SPRITE_MASK >> pix_idx;

    // Clipped pixels still consume their cycle but leave the outputs held.
    vga_plot_n   = pix_en && (pix_y < 8'(SCREEN_H));
    vga_x_n      = vga_x;
    vga_y_n      = vga_y;
    vga_colour_n = vga_colour;
    if (vga_plot_n) begin
      vga_x_n      = pix_x;
      vga_y_n      = pix_y[6:0];
      vga_colour_n = (!pix_erase && mask_shift[0]) ? SPRITE_COLOUR : BG_COLOUR;
    end
  end

endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
// Bench for snoopy_sprite_drawer: a schedule model predicts every output cycle,
// and directed updates are pinned with hand-computed counts and coordinates.
module tb_snoopy_sprite_drawer;

  localparam int W = 8;
  localparam int H = 8;
  localparam int SX = 20;
  localparam int SH = 120;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [6:0] snoopy_y = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  snoopy_sprite_drawer dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .snoopy_y(snoopy_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       plot;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t expv = '0;
  bit   armed = 0;
  bit   m_valid = 0;
  int   m_y = 0;
  logic [7:0] lx = '0;
  logic [6:0] ly = '0;
  logic [2:0] lc = '0;
  logic [63:0] mask = '1;

  // Append one full scan (erase or draw) to the expected schedule.
  task automatic push_scan(input int base, input bit erase);
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int cc = 0; cc < W; cc++) begin
        e = '0;
        e.busy = 1'b1;
        if (base + r < SH) begin
          lx = 8'(SX + cc);
          ly = 7'(base + r);
          lc = (!erase && mask[r*W+cc]) ? 3'b111 : 3'b000;
          e.plot = 1'b1;
        end
        e.x = lx; e.y = ly; e.c = lc;
        q.push_back(e);
      end
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    armed = 1;
    if (!reset) begin
      q.delete();
      m_valid = 0; m_y = 0;
      lx = '0; ly = '0; lc = '0;
      expv = '0;
    end else begin
      if (q.size() == 0 && !expv.busy && frame_tick) begin
        if (!(m_valid && m_y == int'(snoopy_y))) begin
          if (m_valid) push_scan(m_y, 1);
          push_scan(int'(snoopy_y), 0);
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        e.x = lx; e.y = ly; e.c = lc;
        q.push_back(e);
        m_valid = 1; m_y = int'(snoopy_y);
      end
      if (q.size() > 0) expv = q.pop_front();
      else begin
        expv = '0; expv.x = lx; expv.y = ly; expv.c = lc;
      end
    end
  end

  always @(negedge clock) begin
    exp_t act;
    if (armed) begin
      act = '{vga_plot, busy, done, vga_x, vga_y, vga_colour};
      tests++;
      if (act !== expv) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t actual plot=%b busy=%b done=%b x=%0d y=%0d c=%0d required plot=%b busy=%b done=%b x=%0d y=%0d c=%0d",
                 $time, act.plot, act.busy, act.done, act.x, act.y, act.c,
                 expv.plot, expv.busy, expv.done, expv.x, expv.y, expv.c);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  int plots, bg, first_done, dones, busy_cnt, fx, fy, lxx, lyy;

  // Raise frame_tick for tick_cycles cycles (cycle 0 onward) and watch cycles 1..window.
  task automatic run_update(input logic [6:0] y, input int tick_cycles, input int window);
    plots = 0; bg = 0; first_done = -1; dones = 0; busy_cnt = 0;
    fx = -1; fy = -1; lxx = -1; lyy = -1;
    snoopy_y = y;
    frame_tick = 1'b1;
    for (int k = 1; k <= window; k++) begin
      @(negedge clock);
      if (k >= tick_cycles) frame_tick = 1'b0;
      if (vga_plot === 1'b1) begin
        plots++;
        if (vga_colour === 3'b000) bg++;
        if (fx < 0) begin fx = int'(vga_x); fy = int'(vga_y); end
        lxx = int'(vga_x); lyy = int'(vga_y);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_outputs", int'({vga_plot, busy, done, vga_x, vga_y, vga_colour}), 0);
    reset = 1'b1;

    run_update(7'd100, 1, 70);
    check("first_plots", plots, 64);
    check("first_bg", bg, 0);
    check("first_done", first_done, 65);
    check("first_busy", busy_cnt, 65);
    check("first_px", fx * 1000 + fy, 20100);
    check("last_px", lxx * 1000 + lyy, 27107);

    run_update(7'd100, 1, 5);
    check("same_plots", plots, 0);
    check("same_done", first_done, 1);
    check("same_dones", dones, 1);

    run_update(7'd90, 1, 135);
    check("move_plots", plots, 128);
    check("move_bg", bg, 64);
    check("move_done", first_done, 129);
    check("move_first_px", fx * 1000 + fy, 20100);
    check("move_last_px", lxx * 1000 + lyy, 27097);

    run_update(7'd50, 131, 140);
    check("hold_dones", dones, 2);
    check("hold_plots", plots, 128);
    check("hold_first_done", first_done, 129);

    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    run_update(7'd116, 1, 70);
    check("clip_plots", plots, 32);
    check("clip_done", first_done, 65);
    check("clip_last_px", lxx * 1000 + lyy, 27119);

    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    run_update(7'd10, 1, 30);
    reset = 1'b0;
    @(negedge clock);
    check("midreset_outputs", int'({vga_plot, busy, done, vga_x, vga_y, vga_colour}), 0);
    reset = 1'b1;
    run_update(7'd40, 1, 70);
    check("after_reset_plots", plots, 64);
    check("after_reset_bg", bg, 0);
    check("after_reset_done", first_done, 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snoopy_sprite_drawer.md
# snoopy_sprite_drawer

Pixel-plotting back end for the vertical position produced by the Snoopy jump controller. On each frame strobe it samples the 7-bit Snoopy Y coordinate. If the position changed, it erases the previously drawn sprite and draws the new one as a one-pixel-per-cycle stream into the VGA adapter's plot port. It sits between the vertical FSM (`snoopy_y`) and the frame-buffer VGA adapter, and reports completion so the top level can pace the game loop.

## Interface
- SNOOPY_X, 20: fixed left column of the sprite (8-bit screen X).
- SPRITE_W, 8: sprite width in pixels (1..16).
- SPRITE_H, 8: sprite height in pixels (1..16).
- SCREEN_H, 120: visible rows; rows at or beyond this are clipped.
- SPRITE_MASK, 64'hFFFF_FFFF_FFFF_FFFF: SPRITE_W*SPRITE_H bitmap.
  - Bit index is row*SPRITE_W+col.
  - 1 selects SPRITE_COLOUR; 0 selects BG_COLOUR.
- SPRITE_COLOUR, 3'b111: foreground colour.
- BG_COLOUR, 3'b000: background/erase colour.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- frame_tick  in  1  one-cycle frame strobe; starts an update when idle.
- snoopy_y  in  7  current sprite top row from the vertical FSM.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe; vga_x/vga_y/vga_colour are valid when high.
- busy  out  1  update in progress.
- done  out  1  one-cycle pulse when an update finishes, including skipped updates.

## Operation
- Internal state:
  - drawn_y (7b): top row of the sprite currently on screen.
  - drawn_valid: a sprite is on screen.
  - new_y (7b): position sampled at the frame strobe.
  - col and row counters.
  - FSM with states S_IDLE, S_ERASE, S_DRAW, S_DONE.
- Reset (reset==0 at a clock edge): all outputs 0, FSM to S_IDLE, drawn_valid=0, drawn_y=0, counters 0.
- S_IDLE: on frame_tick=1, latch new_y<=snoopy_y and clear col and row, then:
  - drawn_valid && snoopy_y==drawn_y → S_DONE (skip; no pixels plotted).
  - drawn_valid && snoopy_y!=drawn_y → S_ERASE.
  - !drawn_valid → S_DRAW.
- S_ERASE: one pixel per cycle over the sprite area at base drawn_y, colour BG_COLOUR for every pixel, mask ignored.
- S_DRAW: one pixel per cycle over the sprite area at base new_y, colour from SPRITE_MASK.
- Pixel scan order: raster, col 0..SPRITE_W-1 inner loop, row 0..SPRITE_H-1 outer loop.
  - vga_x = SNOOPY_X + col.
  - vga_y = base + row.
  - The sum is computed 8-bit wide.
- Clipping: if base+row ≥ SCREEN_H, vga_plot=0 for that pixel but the cycle is still consumed. Scan length is constant.
- At the last pixel (col=W-1, row=H-1):
  - S_ERASE → S_DRAW, counters cleared.
  - S_DRAW → S_DONE.
- S_DONE: done=1 for one cycle, drawn_y<=new_y, drawn_valid<=1, then → S_IDLE.
- frame_tick outside S_IDLE is ignored (not queued). snoopy_y changes during an update have no effect until the next accepted tick.
- vga_x/vga_y/vga_colour hold their last values while vga_plot=0.

## Timing
- All outputs are registered. Let N = SPRITE_W*SPRITE_H.
- Tick accepted in cycle 0 (sampled at the end of cycle 0):
  - First draw (no prior sprite): vga_plot pixels in cycles 1..N; done and busy in cycle N+1.
  - Moved: erase pixels in cycles 1..N, draw pixels in cycles N+1..2N, done in cycle 2N+1.
  - Unchanged: done in cycle 1, no plot.
- busy is high from cycle 1 through the done cycle inclusive; low in S_IDLE.
- A new tick is accepted in the cycle after done at the earliest.
- Reset mid-update:
  - Outputs are forced to 0 at that edge; the scan aborts.
  - drawn_valid=0, so the next tick draws without erasing.
  - The screen may retain partial pixels; this is accepted.

## Test plan
- Reset, then frame_tick with snoopy_y=100, default params:
  - 64 plots, x 20..27, y 100..107, colour 3'b111, raster order.
  - done in cycle 65, busy high cycles 1..65.
- Then frame_tick with snoopy_y=100 again:
  - no vga_plot; done in cycle 1 only.
- Then snoopy_y=90 and frame_tick:
  - 64 BG plots at y 100..107, followed by 64 SPRITE plots at y 90..97.
  - done in cycle 129.
- snoopy_y=116, SCREEN_H=120, first draw:
  - rows 116..119 plotted (32 plots); rows 120..123 clipped.
  - done still in cycle 65.
- Hold frame_tick high for the whole update:
  - exactly one update.
  - The next update starts from the tick sampled in the cycle after done.
- Assert reset in cycle 30 of a draw:
  - all outputs 0 the next cycle.
  - The subsequent tick performs a draw only, with no erase phase.
